// File: rtl/cache_pkg.sv
// Shared definitions for the 2-way, 32-set cache tag path.
//   TAG_W/IDX_W/OFF_W/ADDR_W : address field widths (tag | index | offset)
//   WAYS, SETS               : cache geometry
//   state_e                  : lookup/refill controller states
//   addr_tag/addr_idx        : field extraction from a byte address
//   line_addr                : line-aligned address built from tag and index
package cache_pkg;

  localparam int TAG_W  = 23;
  localparam int IDX_W  = 5;
  localparam int OFF_W  = 4;
  localparam int ADDR_W = TAG_W + IDX_W + OFF_W;
  localparam int WAYS   = 2;
  localparam int SETS   = 1 << IDX_W;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LOOKUP    = 2'd1,
    MISS_REQ  = 2'd2,
    REFILL_WR = 2'd3
  } state_e;

  function automatic logic [TAG_W-1:0] addr_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1 -: TAG_W];
  endfunction

  function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] addr);
    return addr[OFF_W +: IDX_W];
  endfunction

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                  input logic [IDX_W-1:0] idx);
    return {tag, idx, {OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/cache_tag_cmp.sv
// Combinational way compare and victim selection for a 2-way set.
//   valid   : per-way valid bits of the addressed set
//   lru     : way to evict next when both ways are valid
//   tag0/1  : tags read from the array for way 0 / way 1
//   req_tag : tag of the request being looked up
//   hit0/1  : per-way match (valid and equal tag)
//   hit     : either way matched
//   hit_way : matching way, way 0 preferred when both match
//   victim  : first invalid way (way 0 first), otherwise lru
module cache_tag_cmp #(
  parameter int TAG_W = cache_pkg::TAG_W
) (
  input  logic [cache_pkg::WAYS-1:0] valid,
  input  logic                       lru,
  input  logic [TAG_W-1:0]           tag0,
  input  logic [TAG_W-1:0]           tag1,
  input  logic [TAG_W-1:0]           req_tag,
  output logic                       hit0,
  output logic                       hit1,
  output logic                       hit,
  output logic                       hit_way,
  output logic                       victim
);
  import cache_pkg::*;

  always_comb begin
    hit0    = valid[0] && (tag0 == req_tag);
    hit1    = valid[1] && (tag1 == req_tag);
    hit     = hit0 || hit1;
    hit_way = !hit0;
    if (!valid[0]) begin
      victim = 1'b0;
    end else if (!valid[1]) begin
      victim = 1'b1;
    end else begin
      victim = lru;
    end
  end

endmodule

// File: rtl/cache_tag_ctrl.sv
// Lookup and refill controller for the 2-way, 32-set cache tag store.
// Drives the tag array wrapper (1-cycle registered read), keeps valid and
// LRU state in flops and sequences line refills with the memory side.
//
// Ports:
//   CK, RST           : clock, synchronous active-high reset
//   req_valid/addr    : lookup request; req_ready high when idle
//   resp_valid/hit/way: one-cycle response (hit, or miss after refill)
//   mem_req/addr/ack  : refill handshake, mem_req held until mem_ack
//   ta_cs/oe/web/a/di : tag array controls (web is per-way, active-low)
//   ta_do0/ta_do1     : tag array read data, valid one cycle after ta_a
//
// Optional build macro CACHE_STATS_EN adds hit_cnt/miss_cnt response
// counters (32-bit, wrapping, cleared by RST).
//
// The address field widths must match cache_pkg, whose helpers do the
// field slicing.
module cache_tag_ctrl #(
  parameter int ADDR_W = cache_pkg::ADDR_W,
  parameter int TAG_W  = cache_pkg::TAG_W,
  parameter int IDX_W  = cache_pkg::IDX_W,
  parameter int OFF_W  = cache_pkg::OFF_W
) (
  input  logic              CK,
  input  logic              RST,
  input  logic              req_valid,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              req_ready,
  output logic              resp_valid,
  output logic              resp_hit,
  output logic              resp_way,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic              mem_ack,
  output logic              ta_cs,
  output logic              ta_oe,
  output logic [1:0]        ta_web,
  output logic [IDX_W-1:0]  ta_a,
  output logic [TAG_W-1:0]  ta_di,
  input  logic [TAG_W-1:0]  ta_do0,
  input  logic [TAG_W-1:0]  ta_do1
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]       hit_cnt,
  output logic [31:0]       miss_cnt
`endif
);
  import cache_pkg::*;

  localparam int NSETS = 1 << IDX_W;

  state_e                   state_q, state_d;
  logic [TAG_W-1:0]         tag_q, tag_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     victim_q, victim_d;
  logic [NSETS-1:0][1:0]    valid_q, valid_d;
  logic [NSETS-1:0]         lru_q, lru_d;
  logic                     resp_valid_q, resp_valid_d;
  logic                     resp_hit_q, resp_hit_d;
  logic                     resp_way_q, resp_way_d;
  logic                     mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]        mem_addr_q, mem_addr_d;
`ifdef CACHE_STATS_EN
  logic [31:0]              hit_cnt_q, hit_cnt_d;
  logic [31:0]              miss_cnt_q, miss_cnt_d;
`endif

  logic cmp_hit0, cmp_hit1, cmp_hit, cmp_hit_way, cmp_victim;

  // Compare against the set captured at acceptance; the array data returned
  // during LOOKUP belongs to that same set.
  cache_tag_cmp #(.TAG_W(TAG_W)) u_cmp (
    .valid   (valid_q[idx_q]),
    .lru     (lru_q[idx_q]),
    .tag0    (ta_do0),
    .tag1    (ta_do1),
    .req_tag (tag_q),
    .hit0    (cmp_hit0),
    .hit1    (cmp_hit1),
    .hit     (cmp_hit),
    .hit_way (cmp_hit_way),
    .victim  (cmp_victim)
  );

  always_comb begin
    state_d      = state_q;
    tag_d        = tag_q;
    idx_d        = idx_q;
    victim_d     = victim_q;
    valid_d      = valid_q;
    lru_d        = lru_q;
    resp_valid_d = 1'b0;
    resp_hit_d   = resp_hit_q;
    resp_way_d   = resp_way_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          tag_d   = addr_tag(req_addr);
          idx_d   = addr_idx(req_addr);
          state_d = LOOKUP;
        end
      end
      LOOKUP: begin
        if (cmp_hit) begin
          resp_valid_d = 1'b1;
          resp_hit_d   = 1'b1;
          resp_way_d   = cmp_hit_way;
          lru_d[idx_q] = !cmp_hit_way;
          state_d      = IDLE;
        end else begin
          victim_d   = cmp_victim;
          mem_req_d  = 1'b1;
          mem_addr_d = line_addr(tag_q, idx_q);
          state_d    = MISS_REQ;
        end
      end
      MISS_REQ: begin
        // The miss response is registered here so it is visible during the
        // REFILL_WR cycle, i.e. the cycle right after mem_ack.
        if (mem_ack) begin
          mem_req_d    = 1'b0;
          resp_valid_d = 1'b1;
          resp_hit_d   = 1'b0;
          resp_way_d   = victim_q;
          state_d      = REFILL_WR;
        end
      end
      REFILL_WR: begin
        valid_d[idx_q][victim_q] = 1'b1;
        lru_d[idx_q]             = !victim_q;
        state_d                  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef CACHE_STATS_EN
  always_comb begin
    hit_cnt_d  = hit_cnt_q;
    miss_cnt_d = miss_cnt_q;
    if (resp_valid_d && resp_hit_d) begin
      hit_cnt_d = hit_cnt_q + 32'd1;
    end
    if (resp_valid_d && !resp_hit_d) begin
      miss_cnt_d = miss_cnt_q + 32'd1;
    end
  end
`endif

  always_ff @(posedge CK) begin
    if (RST) begin
      state_q      <= IDLE;
      valid_q      <= '0;
      lru_q        <= '0;
      resp_valid_q <= 1'b0;
      resp_hit_q   <= 1'b0;
      resp_way_q   <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= '0;
`ifdef CACHE_STATS_EN
      hit_cnt_q    <= '0;
      miss_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      lru_q        <= lru_d;
      resp_valid_q <= resp_valid_d;
      resp_hit_q   <= resp_hit_d;
      resp_way_q   <= resp_way_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
`ifdef CACHE_STATS_EN
      hit_cnt_q    <= hit_cnt_d;
      miss_cnt_q   <= miss_cnt_d;
`endif
    end
  end

  // Request fields and victim are datapath only; state decides when they matter.
  always_ff @(posedge CK) begin
    tag_q    <= tag_d;
    idx_q    <= idx_d;
    victim_q <= victim_d;
  end

  always_comb begin
    req_ready = (state_q == IDLE) && !RST;
    ta_cs     = 1'b1;
    ta_oe     = 1'b1;
    ta_di     = tag_q;
    // In IDLE the array is addressed straight from the request so its data
    // arrives in LOOKUP; otherwise it stays on the captured set.
    ta_a      = (state_q == IDLE) ? addr_idx(req_addr) : idx_q;
    // Reset gates the write so an aborted refill never touches the array.
    ta_web    = 2'b11;
    if ((state_q == REFILL_WR) && !RST) begin
      ta_web = victim_q ? 2'b01 : 2'b10;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_hit   = resp_hit_q;
  assign resp_way   = resp_way_q;
  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
`ifdef CACHE_STATS_EN
  assign hit_cnt    = hit_cnt_q;
  assign miss_cnt   = miss_cnt_q;
`endif

endmodule

// File: tb/tb_cache_tag_ctrl.sv
// Scoreboard bench for cache_tag_ctrl: a behavioural tag array, a memory
// responder, and a set/way reference model based on per-line recency stamps.
module tb_cache_tag_ctrl;
  import cache_pkg::*;

  logic              CK = 1'b0;
  logic              RST;
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              resp_valid, resp_hit, resp_way;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic              ta_cs, ta_oe;
  logic [1:0]        ta_web;
  logic [IDX_W-1:0]  ta_a;
  logic [TAG_W-1:0]  ta_di, ta_do0, ta_do1;
`ifdef CACHE_STATS_EN
  logic [31:0]       hit_cnt, miss_cnt;
`endif

  always #5 CK = ~CK;

  cache_tag_ctrl dut (
    .CK(CK), .RST(RST),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .resp_valid(resp_valid), .resp_hit(resp_hit), .resp_way(resp_way),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack),
    .ta_cs(ta_cs), .ta_oe(ta_oe), .ta_web(ta_web), .ta_a(ta_a),
    .ta_di(ta_di), .ta_do0(ta_do0), .ta_do1(ta_do1)
`ifdef CACHE_STATS_EN
    , .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
`endif
  );

  // Behavioural tag array: registered read, per-way active-low write.
  logic [TAG_W-1:0] arr0 [SETS];
  logic [TAG_W-1:0] arr1 [SETS];
  always @(posedge CK) begin
    ta_do0 <= arr0[ta_a];
    ta_do1 <= arr1[ta_a];
    if (!ta_web[0]) arr0[ta_a] <= ta_di;
    if (!ta_web[1]) arr1[ta_a] <= ta_di;
  end

  int cyc = 0;
  always @(posedge CK) cyc <= cyc + 1;

  typedef struct { logic hit; logic way; int issue; } resp_t;
  typedef struct { logic [1:0] web; logic [IDX_W-1:0] a; logic [TAG_W-1:0] di; } wr_t;
  resp_t             exp_resp[$];
  wr_t               exp_wr[$];
  logic [ADDR_W-1:0] exp_mem[$];

  int errors = 0;
  int checks = 0;
  int ack_cyc = 0;
  bit hold_ack = 0;
  int stray_req = 0;
  int stray_done = 0;
  bit mem_seen = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: lines with tag, valid and a last-use stamp per set.
  logic [TAG_W-1:0] m_tag [SETS][2];
  bit               m_val [SETS][2];
  int               m_use [SETS][2];
  int               stamp = 0;
  int               n_hit = 0;
  int               n_miss = 0;

  task automatic model_reset();
    for (int s = 0; s < SETS; s++) begin
      for (int w = 0; w < 2; w++) begin
        m_val[s][w] = 0;
        m_use[s][w] = 0;
      end
    end
    n_hit = 0;
    n_miss = 0;
  endtask

  // Issue one request; expectations are pushed when it is driven.
  task automatic issue(input logic [ADDR_W-1:0] addr);
    int n = 0;
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] idx;
    int way;
    int v;
    resp_t r;
    wr_t   wr;
    @(negedge CK);
    while (!req_ready && n < 200) begin
      @(negedge CK);
      n++;
    end
    if (!req_ready) begin
      chk("req_ready_timeout", 0, 1);
      return;
    end
    tag = TAG_W'(addr >> (IDX_W + OFF_W));
    idx = IDX_W'(addr >> OFF_W);
    way = -1;
    for (int w = 1; w >= 0; w--) begin
      if (m_val[idx][w] && m_tag[idx][w] == tag) way = w;
    end
    stamp++;
    r.issue = cyc;
    if (way >= 0) begin
      m_use[idx][way] = stamp;
      r.hit = 1'b1;
      r.way = way[0];
      n_hit++;
    end else begin
      if (!m_val[idx][0]) v = 0;
      else if (!m_val[idx][1]) v = 1;
      else v = (m_use[idx][0] < m_use[idx][1]) ? 0 : 1;
      m_tag[idx][v] = tag;
      m_val[idx][v] = 1;
      m_use[idx][v] = stamp;
      r.hit = 1'b0;
      r.way = v[0];
      wr.web = (v == 0) ? 2'b10 : 2'b01;
      wr.a   = idx;
      wr.di  = tag;
      exp_wr.push_back(wr);
      exp_mem.push_back((addr >> OFF_W) << OFF_W);
      n_miss++;
    end
    exp_resp.push_back(r);
    req_valid = 1'b1;
    req_addr  = addr;
    @(negedge CK);
    req_valid = 1'b0;
    req_addr  = $urandom;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_resp.size() != 0 || exp_wr.size() != 0 || exp_mem.size() != 0 || !req_ready)
           && n < 500) begin
      @(negedge CK);
      n++;
    end
    chk("drain_complete", (n >= 500), 0);
  endtask

  // Monitor: responses and tag array writes.
  initial begin
    resp_t r;
    wr_t   w;
    forever begin
      @(negedge CK);
      if (!RST && resp_valid) begin
        if (exp_resp.size() == 0) begin
          chk("unexpected_resp", 1, 0);
        end else begin
          r = exp_resp.pop_front();
          chk("resp_hit", resp_hit, r.hit);
          chk("resp_way", resp_way, r.way);
          if (r.hit) chk("hit_latency", cyc, r.issue + 2);
          else       chk("refill_latency", cyc, ack_cyc);
        end
      end
      if (ta_web !== 2'b11) begin
        if (exp_wr.size() == 0) begin
          chk("unexpected_write", ta_web, 2'b11);
        end else begin
          w = exp_wr.pop_front();
          chk("ta_web", ta_web, w.web);
          chk("ta_a", ta_a, w.a);
          chk("ta_di", ta_di, w.di);
        end
      end
    end
  end

  // Memory responder: checks the refill address, acks after a random delay.
  initial begin
    logic [ADDR_W-1:0] ea;
    mem_ack = 1'b0;
    forever begin
      @(negedge CK);
      if (stray_req != stray_done) begin
        mem_ack = 1'b1;
        @(negedge CK);
        mem_ack = 1'b0;
        stray_done = stray_req;
      end else if (!mem_req || RST) begin
        mem_seen = 0;
      end else if (!mem_seen) begin
        mem_seen = 1;
        if (exp_mem.size() == 0) begin
          chk("unexpected_mem_req", 1, 0);
        end else begin
          ea = exp_mem.pop_front();
          chk("mem_addr", mem_addr, ea);
        end
        if (!hold_ack) begin
          repeat ($urandom_range(0, 3)) @(negedge CK);
          chk("mem_req_held", mem_req, 1);
          mem_ack = 1'b1;
          ack_cyc = cyc + 1;
          @(negedge CK);
          mem_ack = 1'b0;
        end
      end
    end
  end

  task automatic check_idle_outputs(input string tagname);
    chk({tagname, "_req_ready"}, req_ready, 1);
    chk({tagname, "_resp_valid"}, resp_valid, 0);
    chk({tagname, "_mem_req"}, mem_req, 0);
    chk({tagname, "_mem_addr"}, mem_addr, 0);
    chk({tagname, "_ta_web"}, ta_web, 2'b11);
  endtask

  initial begin
    int sets[3];
    logic [TAG_W-1:0] t;
    logic [IDX_W-1:0] ix;
    int n;
    sets[0] = 3; sets[1] = 7; sets[2] = 9;
    RST = 1'b1;
    req_valid = 1'b0;
    req_addr = '0;
    model_reset();
    repeat (3) @(negedge CK);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_ta_web", ta_web, 2'b11);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("ta_cs", ta_cs, 1);
    chk("ta_oe", ta_oe, 1);
    RST = 1'b0;
    @(negedge CK);
    check_idle_outputs("post_rst");

    // Directed: cold miss, hit, second way, LRU eviction, LRU after hit.
    issue(32'h0000_1230);
    issue(32'h0000_1230);
    issue(32'h0001_0230);
    issue(32'h0002_0230);
    issue(32'h0002_0230);
    issue(32'h0003_0230);
    issue(32'h0002_023C);
    drain();

    // Randomized traffic over a few sets and a handful of tags.
    for (int i = 0; i < 300; i++) begin
      t  = TAG_W'($urandom_range(0, 4) * 5 + 1);
      ix = IDX_W'(sets[$urandom_range(0, 2)]);
      issue({t, ix, 4'($urandom)});
    end
    drain();

`ifdef CACHE_STATS_EN
    chk("hit_cnt", hit_cnt, n_hit);
    chk("miss_cnt", miss_cnt, n_miss);
`endif

    // Reset while a refill is outstanding; a late mem_ack must be ignored.
    hold_ack = 1;
    issue(32'h0007_0050);
    n = 0;
    while (!mem_req && n < 20) begin
      @(negedge CK);
      n++;
    end
    chk("abort_mem_req_seen", mem_req, 1);
    RST = 1'b1;
    @(negedge CK);
    chk("abort_rst_req_ready", req_ready, 0);
    chk("abort_rst_ta_web", ta_web, 2'b11);
    @(negedge CK);
    RST = 1'b0;
    exp_resp.delete();
    exp_wr.delete();
    exp_mem.delete();
    model_reset();
    stray_req++;
    repeat (4) @(negedge CK);
    check_idle_outputs("after_abort");
`ifdef CACHE_STATS_EN
    chk("hit_cnt_cleared", hit_cnt, 0);
    chk("miss_cnt_cleared", miss_cnt, 0);
`endif
    hold_ack = 0;

    // All lines invalid again: previously cached tags must miss.
    issue(32'h0000_1230);
    issue(32'h0007_0050);
    issue(32'h0000_1230);
    issue(32'h0000_1234);
    issue(32'h0007_0050);
    drain();
`ifdef CACHE_STATS_EN
    chk("hit_cnt_final", hit_cnt, n_hit);
    chk("miss_cnt_final", miss_cnt, n_miss);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
